// File: rtl/m_64spi_slave.sv
// SPI mode-0 slave, MSB first, fully synchronous to clk: SCLK/SS_N/MOSI are
// oversampled through synchronizers and edge-detected into one-cycle strobes.
module m_64spi_slave #(
   parameter int WIDTH       = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             SCLK_SLAVE,
   input  logic             SS_N_SLAVE,
   input  logic             MOSI_SLAVE,
   output logic             MISO_SLAVE,
   input  logic [WIDTH-1:0] tx_data,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             frame_err,
   output logic             busy
);

   // Room for the WIDTH+1 over-length marker as well as the full count.
   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_OVER = CW'(WIDTH + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] ss_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_prev_q;
   logic                   ss_prev_q;

   logic                   sclk_s;
   logic                   ss_s;
   logic                   mosi_s;
   logic                   sclk_rise_s;
   logic                   sclk_fall_s;
   logic                   ss_fall_s;
   logic                   ss_rise_s;

   logic [1:0]             state_q,    state_d;
   logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
   logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
   logic [CW-1:0]          bit_cnt_q,  bit_cnt_d;
   logic [WIDTH-1:0]       rx_data_q,  rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   busy_q,     busy_d;
   logic                   miso_q,     miso_d;
   logic                   pend_q,     pend_d;

   // Synchronizer chains and edge-detect history, preset to idle line levels.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q <= '0;
         ss_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         ss_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK_SLAVE};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_N_SLAVE};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI_SLAVE};
         sclk_prev_q <= sclk_s;
         ss_prev_q   <= ss_s;
      end
   end

   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s        = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise_s = sclk_s & ~sclk_prev_q;
   assign sclk_fall_s = ~sclk_s & sclk_prev_q;
   assign ss_fall_s   = ~ss_s & ss_prev_q;
   assign ss_rise_s   = ss_s & ~ss_prev_q;

   // Frame FSM, shift registers and output next-state.
   always_comb begin
      state_d     = state_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      bit_cnt_d   = bit_cnt_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      pend_d      = pend_q;
      case (state_q)
         S_IDLE: begin
            if (ss_fall_s || pend_q) begin
               tx_shift_d = tx_data;
               bit_cnt_d  = '0;
               pend_d     = 1'b0;
               state_d    = S_ACTIVE;
            end else begin
               pend_d = 1'b0;
            end
         end
         S_ACTIVE: begin
            if (ss_rise_s) begin
               state_d = S_DONE;
            end else if (sclk_rise_s) begin
               if (bit_cnt_q < CNT_FULL) begin
                  rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                  bit_cnt_d  = bit_cnt_q + {{(CW-1){1'b0}}, 1'b1};
               end else begin
                  bit_cnt_d = CNT_OVER;
               end
            end else if (sclk_fall_s) begin
               // The fall after the last bit also shifts, so over-length bits read back as 0.
               if (bit_cnt_q != CNT_OVER) begin
                  tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
               end else begin
                  tx_shift_d = tx_shift_q;
               end
            end else begin
               state_d = S_ACTIVE;
            end
         end
         S_DONE: begin
            if (bit_cnt_q == CNT_FULL) begin
               rx_data_d  = rx_shift_q;
               rx_valid_d = 1'b1;
            end else begin
               frame_err_d = 1'b1;
            end
            pend_d  = ss_fall_s;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      miso_d = (state_d == S_ACTIVE) ? tx_shift_d[WIDTH-1] : 1'b0;
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         bit_cnt_q   <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         miso_q      <= 1'b0;
         pend_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         miso_q      <= miso_d;
         pend_q      <= pend_d;
      end
   end

   assign MISO_SLAVE = miso_q;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

endmodule
